// File: rtl/lifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lifo_arb_pkg
// Description : Shared types and constants for the LIFO request arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package lifo_arb_pkg;

  // Arbiter controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  // Request operation encoding carried on req_op_i
  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  // Default stack word width
  localparam int DATA_BITS_DEF = 32;

  // Width of a requester index; never narrower than one bit
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : lifo_arb_pkg
`default_nettype wire

// File: rtl/lifo_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : lifo_rr_pick
// Description : Combinational round-robin picker. The search begins at the
//               requester after last_i and wraps; first active request wins.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_id_o
);

  // Rotating priority search starting one past the last winner
  always_comb begin
    logic found;
    int   idx;
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_i) + off) % NUM_REQ;
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_id_o   = ID_W'(idx);
      end
    end
  end

endmodule : lifo_rr_pick
`default_nettype wire

// File: rtl/lifo_arb.sv
`default_nettype none
// ============================================================================
// Module      : lifo_arb
// Description : Arbitrates several push/pop requesters onto one external LIFO.
//               One transaction at a time: grant, issue, respond. Clear
//               requests arriving mid-transaction are remembered and serviced
//               on the next return to idle, ahead of any new grant.
// Revision    : 1.0 - initial release
// ============================================================================
module lifo_arb
  import lifo_arb_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int NUM_REQ   = 2,
  parameter int ID_W      = id_width(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_i,
  input  logic [NUM_REQ-1:0]           req_valid_i,
  input  logic [NUM_REQ-1:0]           req_op_i,
  input  logic [NUM_REQ*DATA_BITS-1:0] req_data_i,
  output logic [NUM_REQ-1:0]           req_ready_o,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [ID_W-1:0]              resp_id_o,
  output logic [DATA_BITS-1:0]         resp_data_o,
  output logic                         resp_err_o,
  output logic                         lifo_enb_o,
  output logic                         lifo_push_o,
  output logic                         lifo_pop_o,
  output logic                         lifo_clr_o,
  output logic [DATA_BITS-1:0]         lifo_data_o,
  input  logic [DATA_BITS-1:0]         lifo_dout_i,
  input  logic                         lifo_full_i,
  input  logic                         lifo_empty_i
);

  state_e                state_q, state_d;
  logic                  pend_clr_q, pend_clr_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic                  op_q, op_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [DATA_BITS-1:0]  resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [ID_W-1:0]       w_gnt_id;
  logic [DATA_BITS-1:0]  w_sel_data;
  logic                  w_sel_op;
  logic                  w_legal;

  lifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_i    (req_valid_i),
    .last_i   (last_q),
    .gnt_o    (w_gnt),
    .gnt_id_o (w_gnt_id)
  );

  // Route the winning requester's op and data toward the capture registers
  always_comb begin
    w_sel_data = '0;
    w_sel_op   = OP_PUSH;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_sel_data = req_data_i[k*DATA_BITS +: DATA_BITS];
        w_sel_op   = req_op_i[k];
      end
    end
  end

  // A latched op is legal unless it would overflow or underflow the LIFO
  assign w_legal = (op_q == OP_PUSH) ? !lifo_full_i : !lifo_empty_i;

  // State and transaction registers; reset abandons any in-flight request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_clr_q  <= 1'b0;
      last_q      <= ID_W'(NUM_REQ - 1);
      op_q        <= OP_PUSH;
      data_q      <= '0;
      id_q        <= '0;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_clr_q  <= pend_clr_d;
      last_q      <= last_d;
      op_q        <= op_d;
      data_q      <= data_d;
      id_q        <= id_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
    end
  end

  // Next-state logic and all strobes/handshakes, decoded from the current state
  always_comb begin
    state_d      = state_q;
    pend_clr_d   = pend_clr_q;
    last_d       = last_q;
    op_d         = op_q;
    data_d       = data_q;
    id_d         = id_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    req_ready_o  = '0;
    resp_valid_o = 1'b0;
    resp_id_o    = '0;
    resp_data_o  = '0;
    resp_err_o   = 1'b0;
    lifo_enb_o   = 1'b0;
    lifo_push_o  = 1'b0;
    lifo_pop_o   = 1'b0;
    lifo_clr_o   = 1'b0;
    lifo_data_o  = '0;

    // Clears seen while busy are deferred until the next idle cycle
    if (clr_i && (state_q != ST_IDLE)) begin
      pend_clr_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (clr_i || pend_clr_q) begin
          state_d = ST_CLEAR;
        end else if (|req_valid_i) begin
          req_ready_o = w_gnt;
          last_d      = w_gnt_id;
          id_d        = w_gnt_id;
          op_d        = w_sel_op;
          data_d      = w_sel_data;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (w_legal) begin
          lifo_enb_o = 1'b1;
          if (op_q == OP_PUSH) begin
            lifo_push_o = 1'b1;
            lifo_data_o = data_q;
            resp_data_d = '0;
          end else begin
            lifo_pop_o  = 1'b1;
            resp_data_d = lifo_dout_i;
          end
          resp_err_d = 1'b0;
        end else begin
          resp_data_d = '0;
          resp_err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        resp_valid_o = 1'b1;
        resp_id_o    = id_q;
        resp_data_o  = resp_data_q;
        resp_err_o   = resp_err_q;
        if (resp_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        lifo_clr_o = 1'b1;
        pend_clr_d = clr_i;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule : lifo_arb
`default_nettype wire

// File: doc/lifo_arb.md
LIFO_ARB -- requirements
Module: lifo_arb

Interface
REQ-001 Parameter DATA_BITS, default 32, width of stack data words.
REQ-002 Parameter NUM_REQ, default 2, number of requesters sharing one LIFO.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clr_i  input  1  pulse request to empty the shared LIFO.
REQ-006 req_valid_i  input  NUM_REQ  per-requester request valid.
REQ-007 req_op_i  input  NUM_REQ  per-requester op; 0 = push, 1 = pop.
REQ-008 req_data_i  input  NUM_REQ*DATA_BITS  per-requester push data, requester k in slice k.
REQ-009 req_ready_o  output  NUM_REQ  one-hot acceptance of a request.
REQ-010 resp_valid_o  output  1  response valid, held until resp_ready_i.
REQ-011 resp_ready_i  input  1  response consumer ready.
REQ-012 resp_id_o  output  $clog2(NUM_REQ) (min 1)  index of requester being answered.
REQ-013 resp_data_o  output  DATA_BITS  popped word; 0 for push or error.
REQ-014 resp_err_o  output  1  1 = push while full or pop while empty; LIFO untouched.
REQ-015 lifo_enb_o, lifo_push_o, lifo_pop_o, lifo_clr_o  output  1 each  LIFO strobes.
REQ-016 lifo_data_o  output  DATA_BITS  push data to LIFO.
REQ-017 lifo_dout_i  input  DATA_BITS  LIFO combinational read data, valid while lifo_pop_o=1.
REQ-018 lifo_full_i, lifo_empty_i  input  1 each  LIFO status flags.

Function
REQ-019 FSM states IDLE, ISSUE, RESP, CLEAR; encoding from shared package.
REQ-020 IDLE: clr_i (or pending clear) -> CLEAR; else any req_valid_i -> pick winner, assert its req_ready_o that cycle, latch op/data/id, -> ISSUE.
REQ-021 Arbitration round-robin: search starts at requester after last granted; after reset last granted = NUM_REQ-1 (requester 0 first).
REQ-022 ISSUE lasts exactly one cycle: legal push -> lifo_enb_o=lifo_push_o=1, lifo_data_o = latched data; legal pop -> lifo_enb_o=lifo_pop_o=1, lifo_dout_i captured into resp_data_o register.
REQ-023 Legality decided in ISSUE from lifo_full_i/lifo_empty_i: illegal op drives no strobe, sets resp_err_o=1, resp_data_o=0; -> RESP.
REQ-024 RESP: resp_valid_o=1 with stable id/data/err; leave to IDLE on cycle resp_valid_o & resp_ready_i; no new grant same cycle.
REQ-025 Request-to-response latency minimum 2 cycles (grant cycle, ISSUE, resp_valid_o asserted next cycle).
REQ-026 CLEAR: lifo_clr_o=1 for exactly one cycle, no response generated, -> IDLE.
REQ-027 clr_i seen outside IDLE sets a pending-clear flag; serviced on next IDLE entry before any grant; flag cleared in CLEAR.
REQ-028 clr_i and req_valid_i same IDLE cycle: clear wins, no req_ready_o asserted.
REQ-029 lifo_push_o and lifo_pop_o never both 1; all LIFO strobes 0 outside ISSUE/CLEAR.
REQ-030 req_ready_o at most one bit set, only in IDLE.

Reset
REQ-031 rst asserted (any state, mid-transaction included): state IDLE, all outputs 0, pending clear 0, last-granted = NUM_REQ-1; in-flight request dropped.

Structure
REQ-032 Package lifo_arb_pkg holds state enum, op encoding (OP_PUSH=0, OP_POP=1), DATA_BITS default.
REQ-033 Round-robin picker is sub-module lifo_rr_pick (NUM_REQ requests, last-grant in, one-hot grant out, combinational).

Verification
REQ-034 Req0 push 0xA5 on empty LIFO -> one-cycle lifo_push_o with data 0xA5, then resp id=0 err=0 data=0.
REQ-035 Req0 and req1 valid continuously -> grants alternate 0,1,0,1.
REQ-036 Pop on empty -> no lifo strobe, resp err=1 data=0; push with lifo_full_i=1 -> err=1, no strobe.
REQ-037 clr_i during RESP with resp_ready_i=0 for 3 cycles -> after handshake, lifo_clr_o one cycle before next grant.
REQ-038 rst pulsed during ISSUE -> all outputs 0 next cycle; first later grant goes to requester 0.
